// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage boundaries.
//
// Contents:
//   - Payload widths for each inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   - Field offsets, so each stage packs and unpacks its payload from one table.
//   - A packed struct for the ID/EX payload, the default elastic-stage payload.
//   - The fill state of an elastic stage and its entry-count helper.
package pipe_pkg;

    // IF/ID payload: {pc_inc, instr}
    localparam int IFID_INSTR_LSB  = 0;
    localparam int IFID_PC_INC_LSB = 16;
    localparam int IFID_W          = 32;

    // ID/EX payload: {pc_inc, rdata_1, rdata_2, ext_data, hbu_imm, rd_1, rd_2, wd}
    localparam int IDEX_WD_LSB       = 0;
    localparam int IDEX_RD_2_LSB     = 4;
    localparam int IDEX_RD_1_LSB     = 8;
    localparam int IDEX_HBU_IMM_LSB  = 12;
    localparam int IDEX_EXT_DATA_LSB = 20;
    localparam int IDEX_RDATA_2_LSB  = 36;
    localparam int IDEX_RDATA_1_LSB  = 52;
    localparam int IDEX_PC_INC_LSB   = 68;
    localparam int IDEX_W            = 84;

    // EX/MEM payload: {pc_inc, alu_out, rdata_2, wd}
    localparam int EXMEM_WD_LSB      = 0;
    localparam int EXMEM_RDATA_2_LSB = 4;
    localparam int EXMEM_ALU_LSB     = 20;
    localparam int EXMEM_PC_INC_LSB  = 36;
    localparam int EXMEM_W           = 52;

    // MEM/WB payload: {alu_out, mem_data, wd}
    localparam int MEMWB_WD_LSB   = 0;
    localparam int MEMWB_MEM_LSB  = 4;
    localparam int MEMWB_ALU_LSB  = 20;
    localparam int MEMWB_W        = 36;

    // Field order matches the IDEX_*_LSB offsets above (MSB first).
    typedef struct packed {
        logic [15:0] pc_inc;
        logic [15:0] rdata_1;
        logic [15:0] rdata_2;
        logic [15:0] ext_data;
        logic [7:0]  hbu_imm;
        logic [3:0]  rd_1;
        logic [3:0]  rd_2;
        logic [3:0]  wd;
    } idex_t;

    // Fill state of an elastic stage, named by (main, skid) valid bits.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    function automatic logic [1:0] occ_of(input stage_state_e st);
        case (st)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of an elastic stage: a payload register plus its valid bit.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (valid and payload cleared)
//   clear       synchronous discard: valid drops; payload zeroed if CLR_ON_FLUSH
//   load        capture d into the payload register
//   valid_nxt   next value of the valid bit when not clearing
//   d           payload to capture
//   valid, q    stored valid bit and payload
module pipe_slot #(
    parameter int DATA_W       = 84,
    parameter int CLR_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              valid_nxt,
    input  logic [DATA_W-1:0] d,
    output logic              valid,
    output logic [DATA_W-1:0] q
);

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else begin
            valid <= valid_nxt;
        end
    end

    // NOTE: the payload register is reset as well, because downstream logic
    // observes out_data = 0 immediately after reset; it is a register, not a
    // memory array, so the reset costs nothing structural.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            if (CLR_ON_FLUSH != 0) begin
                q <= '0;
            end
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register for an inter-stage boundary.
//
// Carries one payload word with valid/ready flow control and a synchronous
// flush. With SKID=1 a second (skid) entry absorbs the beat that arrives while
// the downstream stalls, so in_ready is taken straight from a flop and there is
// no combinational path from out_ready to in_ready. With SKID=0 the stage is a
// single entry whose in_ready follows out_ready combinationally.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   flush       synchronous discard of every held entry
//   in_valid    upstream presents a beat      in_ready   stage accepts this cycle
//   in_data     upstream payload
//   out_valid   stage presents a beat         out_ready  downstream accepts
//   out_data    downstream payload (stable while out_valid && !out_ready)
//   occ         number of entries held (0..2, or 0..1 with SKID=0)
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W       = IDEX_W,
    parameter int SKID         = 1,
    parameter int CLR_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    logic              main_v;
    logic              skid_v;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;

    logic              in_fire;
    logic              out_fire;
    logic              main_load;
    logic              main_v_nxt;
    logic [DATA_W-1:0] main_d;
    logic              skid_load;
    logic              skid_v_nxt;
    stage_state_e      state;

    assign out_valid = main_v;
    assign out_data  = main_data;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_v & out_ready;

    // The skid entry only ever fills behind a valid main entry, so skid_v alone
    // identifies FULL.
    assign state = skid_v ? ST_FULL : (main_v ? ST_ONE : ST_EMPTY);
    assign occ   = occ_of(state);

    // Fill/drain control. A flush overrides all of this inside the slots, which
    // is what drops a beat accepted in the flush cycle.
    // NOTE: every output of this block gets a default first, so no path through
    // the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        main_load  = 1'b0;
        main_d     = in_data;
        main_v_nxt = main_v;
        skid_load  = 1'b0;
        skid_v_nxt = skid_v;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_load  = 1'b1;
                    main_v_nxt = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    // Downstream stalled: the new, younger beat parks in the skid entry.
                    skid_load  = 1'b1;
                    skid_v_nxt = 1'b1;
                end else if (out_fire) begin
                    main_v_nxt = 1'b0;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    main_load  = 1'b1;
                    main_d     = skid_data;
                    skid_v_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    pipe_slot #(
        .DATA_W       (DATA_W),
        .CLR_ON_FLUSH (CLR_ON_FLUSH)
    ) u_main (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .load      (main_load),
        .valid_nxt (main_v_nxt),
        .d         (main_d),
        .valid     (main_v),
        .q         (main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .DATA_W       (DATA_W),
                .CLR_ON_FLUSH (CLR_ON_FLUSH)
            ) u_skid (
                .clk       (clk),
                .rst_n     (rst_n),
                .clear     (flush),
                .load      (skid_load),
                .valid_nxt (skid_v_nxt),
                .d         (in_data),
                .valid     (skid_v),
                .q         (skid_data)
            );
            // Registered ready: only the skid valid flop drives it.
            assign in_ready = ~skid_v;
        end else begin : g_single
            // With in_ready = !main_v | out_ready the ONE-state "accept while
            // stalled" branch can never occur, so the skid controls stay idle.
            assign skid_v    = 1'b0;
            assign skid_data = '0;
            assign in_ready  = ~main_v | out_ready;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic.
// Directed scenarios run on a SKID=1, CLR_ON_FLUSH=1 instance; a random
// scenario runs a SKID=0 and a SKID=1 instance against a FIFO scoreboard.
module tb_pipe_stage_elastic;

    localparam int DW = 84;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Directed-test instance
    logic          flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occ;

    // Random-test instances: index 0 is SKID=0, index 1 is SKID=1
    logic          r_flush     [2];
    logic          r_in_valid  [2];
    logic          r_in_ready  [2];
    logic          r_out_valid [2];
    logic          r_out_ready [2];
    logic [DW-1:0] r_in_data   [2];
    logic [DW-1:0] r_out_data  [2];
    logic [1:0]    r_occ       [2];

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] da, db, dc, dd;

    pipe_stage_elastic #(.DATA_W(DW), .SKID(1), .CLR_ON_FLUSH(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occ(occ)
    );

    pipe_stage_elastic #(.DATA_W(DW), .SKID(0), .CLR_ON_FLUSH(1)) rnd0 (
        .clk(clk), .rst_n(rst_n), .flush(r_flush[0]),
        .in_valid(r_in_valid[0]), .in_ready(r_in_ready[0]), .in_data(r_in_data[0]),
        .out_valid(r_out_valid[0]), .out_ready(r_out_ready[0]), .out_data(r_out_data[0]),
        .occ(r_occ[0])
    );

    pipe_stage_elastic #(.DATA_W(DW), .SKID(1), .CLR_ON_FLUSH(0)) rnd1 (
        .clk(clk), .rst_n(rst_n), .flush(r_flush[1]),
        .in_valid(r_in_valid[1]), .in_ready(r_in_ready[1]), .in_data(r_in_data[1]),
        .out_valid(r_out_valid[1]), .out_ready(r_out_ready[1]), .out_data(r_out_data[1]),
        .occ(r_occ[1])
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] beat(input int k, input int s);
        return {20'(k + 1), 32'(s * 13 + 5), 32'(~s)};
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset;
        checks++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_initial: out_valid=%b occ=%0d out_data=%0h want 0/0/0",
                     out_valid, occ, out_data);
        end
        @(negedge clk) rst_n = 1'b1;
        step;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
        // Fill to occ=2, then reset mid-run between clock edges.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = da;
        step;
        in_data = db;
        step;
        in_valid = 1'b0;
        checks++;
        if (occ !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_prefill: occ=%0d in_ready=%b want 2/0", occ, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_async: out_valid=%b occ=%0d out_data=%0h want 0/0/0",
                     out_valid, occ, out_data);
        end
        @(negedge clk) rst_n = 1'b1;
        step;
        checks++;
        if (in_ready !== 1'b1 || occ !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: in_ready=%b occ=%0d out_valid=%b want 1/0/0",
                     in_ready, occ, out_valid);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stream;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = DW'(1);
        step;
        for (int i = 1; i <= 100; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== DW'(i) || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_beat_%0d: out_valid=%b out_data=%0h in_ready=%b want 1/%0h/1",
                         i, out_valid, out_data, in_ready, i);
            end
            if (i < 100) in_data = DW'(i + 1);
            else         in_valid = 1'b0;
            step;
        end
        checks++;
        if (out_valid !== 1'b0 || occ !== 2'd0) begin
            errors++;
            $display("FAIL stream_end: out_valid=%b occ=%0d want 0/0", out_valid, occ);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = da;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_ready_empty: in_ready=%b want 1", in_ready);
        end
        step;
        checks++;
        if (occ !== 2'd1 || out_valid !== 1'b1 || out_data !== da) begin
            errors++;
            $display("FAIL stall_one: occ=%0d out_valid=%b out_data=%0h want 1/1/%0h",
                     occ, out_valid, out_data, da);
        end
        in_data = db;
        step;
        checks++;
        if (occ !== 2'd2 || in_ready !== 1'b0 || out_data !== da) begin
            errors++;
            $display("FAIL stall_full: occ=%0d in_ready=%b out_data=%0h want 2/0/%0h",
                     occ, in_ready, out_data, da);
        end
        in_data = dc;
        step;
        step;
        checks++;
        if (occ !== 2'd2 || in_ready !== 1'b0 || out_data !== da) begin
            errors++;
            $display("FAIL stall_hold: occ=%0d in_ready=%b out_data=%0h want 2/0/%0h",
                     occ, in_ready, out_data, da);
        end
        out_ready = 1'b1;
        step;
        checks++;
        if (out_valid !== 1'b1 || out_data !== db || occ !== 2'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_b: out_valid=%b out_data=%0h occ=%0d in_ready=%b want 1/%0h/1/1",
                     out_valid, out_data, occ, in_ready, db);
        end
        step;
        checks++;
        if (out_valid !== 1'b1 || out_data !== dc || occ !== 2'd1) begin
            errors++;
            $display("FAIL stall_release_c: out_valid=%b out_data=%0h occ=%0d want 1/%0h/1",
                     out_valid, out_data, occ, dc);
        end
        in_valid = 1'b0;
        step;
        checks++;
        if (out_valid !== 1'b0 || occ !== 2'd0) begin
            errors++;
            $display("FAIL stall_drained: out_valid=%b occ=%0d want 0/0", out_valid, occ);
        end
        out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = da;
        step;
        in_data = db;
        step;
        in_data = dc;
        flush   = 1'b1;
        checks++;
        if (in_ready !== 1'b0 || occ !== 2'd2) begin
            errors++;
            $display("FAIL flush_full_cycle: in_ready=%b occ=%0d want 0/2", in_ready, occ);
        end
        step;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || out_data !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full_after: out_valid=%b occ=%0d out_data=%0h in_ready=%b want 0/0/0/1",
                     out_valid, occ, out_data, in_ready);
        end
        // One entry held; a beat accepted during the flush cycle must be dropped.
        in_valid = 1'b1;
        in_data  = da;
        step;
        in_data = dd;
        flush   = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_one_ready: in_ready=%b want 1", in_ready);
        end
        step;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL flush_one_after: out_valid=%b occ=%0d out_data=%0h want 0/0/0",
                     out_valid, occ, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if (out_valid !== 1'b0 || occ !== 2'd0) begin
                errors++;
                $display("FAIL flush_ghost_%0d: out_valid=%b occ=%0d want 0/0", i, out_valid, occ);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush_drain;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = da;
        step;
        in_valid = 1'b0;
        flush    = 1'b1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== da) begin
            errors++;
            $display("FAIL drain_deliver: out_valid=%b out_data=%0h want 1/%0h",
                     out_valid, out_data, da);
        end
        step;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0 || occ !== 2'd0) begin
                errors++;
                $display("FAIL drain_after_%0d: out_valid=%b occ=%0d want 0/0", i, out_valid, occ);
            end
            step;
        end
        out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    logic [DW-1:0] sb [2][4];
    int            sb_rd  [2];
    int            sb_cnt [2];
    int            seq    [2];
    logic          hold   [2];
    logic [DW-1:0] held   [2];

    task automatic test_random;
        logic in_fire, out_fire;
        for (int k = 0; k < 2; k++) begin
            sb_rd[k]  = 0;
            sb_cnt[k] = 0;
            seq[k]    = 0;
            hold[k]   = 1'b0;
            held[k]   = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                r_in_valid[k]  = ($urandom_range(0, 99) < 70);
                r_in_data[k]   = beat(k, seq[k]);
                r_out_ready[k] = ($urandom_range(0, 99) < 60);
                r_flush[k]     = ($urandom_range(0, 99) < 5);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (hold[k]) begin
                    checks++;
                    if (r_out_valid[k] !== 1'b1 || r_out_data[k] !== held[k]) begin
                        errors++;
                        $display("FAIL rnd%0d_stable cyc %0d: out_valid=%b out_data=%0h want 1/%0h",
                                 k, cyc, r_out_valid[k], r_out_data[k], held[k]);
                    end
                end
                checks++;
                if (r_occ[k] !== 2'(sb_cnt[k])) begin
                    errors++;
                    $display("FAIL rnd%0d_occ cyc %0d: occ=%0d want %0d", k, cyc, r_occ[k], sb_cnt[k]);
                end
                if (r_out_valid[k] === 1'b1) begin
                    checks++;
                    if (sb_cnt[k] == 0 || r_out_data[k] !== sb[k][sb_rd[k]]) begin
                        errors++;
                        $display("FAIL rnd%0d_data cyc %0d: out_data=%0h want %0h (queued %0d)",
                                 k, cyc, r_out_data[k], sb[k][sb_rd[k]], sb_cnt[k]);
                    end
                end
                in_fire  = r_in_valid[k] & r_in_ready[k];
                out_fire = r_out_valid[k] & r_out_ready[k];
                if (out_fire && sb_cnt[k] > 0) begin
                    sb_rd[k]  = (sb_rd[k] + 1) % 4;
                    sb_cnt[k] = sb_cnt[k] - 1;
                end
                if (r_flush[k]) begin
                    sb_cnt[k] = 0;
                end else if (in_fire) begin
                    sb[k][(sb_rd[k] + sb_cnt[k]) % 4] = r_in_data[k];
                    sb_cnt[k] = sb_cnt[k] + 1;
                end
                if (in_fire) seq[k] = seq[k] + 1;
                hold[k] = r_out_valid[k] & ~r_out_ready[k] & ~r_flush[k];
                held[k] = r_out_data[k];
            end
            step;
        end
        for (int k = 0; k < 2; k++) begin
            r_in_valid[k]  = 1'b0;
            r_out_ready[k] = 1'b0;
            r_flush[k]     = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        da = {20'hAAAAA, 32'h1111_0001, 32'hA5A5_0001};
        db = {20'hBBBBB, 32'h2222_0002, 32'h5A5A_0002};
        dc = {20'hCCCCC, 32'h3333_0003, 32'hC3C3_0003};
        dd = {20'hDDDDD, 32'h4444_0004, 32'h3C3C_0004};
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            r_flush[k]     = 1'b0;
            r_in_valid[k]  = 1'b0;
            r_in_data[k]   = '0;
            r_out_ready[k] = 1'b0;
        end
        #2 rst_n = 1'b0;
        #10;
        test_reset;
        test_stream;
        test_stall;
        test_flush;
        test_flush_drain;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
